id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register and execute-operand selection for the 5-stage RV32 pipeline; sits directly upstream of the execute ALU. Captures decoded operands and control, supports stall and flush (bubble insertion), and resolves EX-stage forwarding. Drives the ALU's SrcA/SrcB/ALUControl plus the store data and control that continue to EX/MEM.

Parameters:
word_width, 32, datapath width of operands, PC, immediate and results

Ports:
clk  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
StallE  in  1  hold ID/EX contents
FlushE  in  1  load bubble into ID/EX
ValidD  in  1  decode slot holds a real instruction
PCD  in  word_width  decode PC
RD1D  in  word_width  register file read data 1
RD2D  in  word_width  register file read data 2
ImmExtD  in  word_width  sign-extended immediate
Rs1D  in  5  source register 1 index
Rs2D  in  5  source register 2 index
RdD  in  5  destination register index
ALUControlD  in  3  ALU opcode (000 add, 001 sub, 010 sltu, 110 or, 111 and)
CtrlD  in  7  {RegWrite, MemWrite, ResultSrc[1:0], Branch, Jump, ALUSrc}, bit 6 = RegWrite
ForwardAE  in  2  external forward select for operand A
ForwardBE  in  2  external forward select for operand B
ALUResultM  in  word_width  MEM-stage ALU result
ResultW  in  word_width  WB-stage result
RdM  in  5  MEM-stage destination index
RegWriteM  in  1  MEM-stage write enable
RdW  in  5  WB-stage destination index
RegWriteW  in  1  WB-stage write enable
SrcAE  out  word_width  ALU operand A
SrcBE  out  word_width  ALU operand B
WriteDataE  out  word_width  forwarded rs2 for stores
ALUControlE  out  3  registered ALU opcode
CtrlE  out  7  registered control bundle, same bit map as CtrlD
PCE  out  word_width  registered PC
ImmExtE  out  word_width  registered immediate
Rs1E  out  5  registered rs1 (to hazard unit)
Rs2E  out  5  registered rs2
RdE  out  5  registered rd
ValidE  out  1  execute slot holds a real instruction

Behaviour:
- Registers update on rising clk; reset_n low asynchronously clears every register to 0 (ValidE=0, CtrlE=0, all indices/data 0), at any time including mid-stall.
- Update priority each edge: FlushE > StallE > load. Flush: all registers 0 (bubble, RegWrite/MemWrite/Branch/Jump=0). Stall without flush: hold all. Else: load all D inputs; ValidE <= ValidD.
- ValidD=0 on load: CtrlE forced to 0 (no architectural side effects); data fields loaded as-is.
- Latency: D inputs visible on E outputs one cycle after a load edge.
- Forwarding is combinational from registered fields and current M/W inputs, same cycle. Select: 00 -> RD1E/RD2E, 01 -> ResultW, 10 -> ALUResultM, 11 -> treated as 00.
- SrcAE = forwarded A. WriteDataE = forwarded B. SrcBE = CtrlE[0] (ALUSrc) ? ImmExtE : forwarded B.
- All widths word_width; no arithmetic performed here.

Optional Feature:
Macro ID_EX_INTERNAL_FWD_EN. Defined: ForwardAE/ForwardBE ignored; selects computed internally: 10 if RegWriteM and RdM==RsXE and RsXE!=0; else 01 if RegWriteW and RdW==RsXE and RsXE!=0; else 00 (MEM wins over WB). Undefined: external ForwardAE/ForwardBE used verbatim; RdM/RegWriteM/RdW/RegWriteW unused.

Test Plan:
- Reset: drive reset_n=0 mid-stall with nonzero state -> all outputs 0 immediately, ValidE=0; release, load RD1D=5, RD2D=7, ALUSrc=0 -> next cycle SrcAE=5, SrcBE=7.
- Immediate select: ImmExtD=0xFFFFFFF0, ALUSrc=1, RD2D=3 -> SrcBE=0xFFFFFFF0, WriteDataE=3.
- Stall: load PCD=0x100, assert StallE 3 cycles while PCD=0x104 -> PCE stays 0x100, then 0x104 after release.
- Flush vs stall: StallE=1 and FlushE=1 same edge with CtrlE=0x7F -> CtrlE=0, ValidE=0.
- Forwarding: ForwardAE=10, ForwardBE=01, ALUResultM=0xAA, ResultW=0xBB, ALUSrc=0 -> SrcAE=0xAA, SrcBE=0xBB, WriteDataE=0xBB; ForwardAE=11 -> SrcAE=RD1E.
- Internal mode (macro set): Rs1E=0, RdM=0, RegWriteM=1 -> SrcAE=RD1E; Rs1E=4, RdM=4, RdW=4, both writes set -> SrcAE=ALUResultM.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding muxes.
// Optional: ID_EX_INTERNAL_FWD_EN computes forward selects internally.
module id_ex_stage #(
   parameter int word_width = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  StallE,
   input  logic                  FlushE,
   input  logic                  ValidD,
   input  logic [word_width-1:0] PCD,
   input  logic [word_width-1:0] RD1D,
   input  logic [word_width-1:0] RD2D,
   input  logic [word_width-1:0] ImmExtD,
   input  logic [4:0]            Rs1D,
   input  logic [4:0]            Rs2D,
   input  logic [4:0]            RdD,
   input  logic [2:0]            ALUControlD,
   input  logic [6:0]            CtrlD,
   input  logic [1:0]            ForwardAE,
   input  logic [1:0]            ForwardBE,
   input  logic [word_width-1:0] ALUResultM,
   input  logic [word_width-1:0] ResultW,
   input  logic [4:0]            RdM,
   input  logic                  RegWriteM,
   input  logic [4:0]            RdW,
   input  logic                  RegWriteW,
   output logic [word_width-1:0] SrcAE,
   output logic [word_width-1:0] SrcBE,
   output logic [word_width-1:0] WriteDataE,
   output logic [2:0]            ALUControlE,
   output logic [6:0]            CtrlE,
   output logic [word_width-1:0] PCE,
   output logic [word_width-1:0] ImmExtE,
   output logic [4:0]            Rs1E,
   output logic [4:0]            Rs2E,
   output logic [4:0]            RdE,
   output logic                  ValidE
);

   typedef struct packed {
      logic                  valid;
      logic [6:0]            ctrl;
      logic [2:0]            aluctl;
      logic [word_width-1:0] pc;
      logic [word_width-1:0] rd1;
      logic [word_width-1:0] rd2;
      logic [word_width-1:0] imm;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
   } id_ex_t;

   id_ex_t q;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic [word_width-1:0] op_a;
   logic [word_width-1:0] op_b;

   // Pipeline register: flush beats stall beats load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (FlushE) begin
         q <= '0;
      end else if (!StallE) begin
         q.valid  <= ValidD;
         q.ctrl   <= ValidD ? CtrlD : 7'd0;
         q.aluctl <= ALUControlD;
         q.pc     <= PCD;
         q.rd1    <= RD1D;
         q.rd2    <= RD2D;
         q.imm    <= ImmExtD;
         q.rs1    <= Rs1D;
         q.rs2    <= Rs2D;
         q.rd     <= RdD;
      end
   end

`ifdef ID_EX_INTERNAL_FWD_EN
   logic unused_fwd;
   assign unused_fwd = ^{ForwardAE, ForwardBE};

   function automatic logic [1:0] fsel(input logic [4:0] rs);
      logic [1:0] s;
      s = 2'b00;
      if (RegWriteM && (RdM == rs) && (rs != 5'd0))
         s = 2'b10;
      else if (RegWriteW && (RdW == rs) && (rs != 5'd0))
         s = 2'b01;
      return s;
   endfunction

   // MEM result takes precedence over WB for the same register.
   always_comb begin
      fwd_a = fsel(q.rs1);
      fwd_b = fsel(q.rs2);
   end
`else
   logic unused_hz;
   assign unused_hz = ^{RdM, RegWriteM, RdW, RegWriteW};

   // Hazard unit supplies the selects directly.
   always_comb begin
      fwd_a = ForwardAE;
      fwd_b = ForwardBE;
   end
`endif

   // Operand muxes; select 11 falls back to the register value.
   always_comb begin
      unique case (1'b1)
         (fwd_a == 2'b10): op_a = ALUResultM;
         (fwd_a == 2'b01): op_a = ResultW;
         default:          op_a = q.rd1;
      endcase
      unique case (1'b1)
         (fwd_b == 2'b10): op_b = ALUResultM;
         (fwd_b == 2'b01): op_b = ResultW;
         default:          op_b = q.rd2;
      endcase
   end

   assign SrcAE       = op_a;
   assign WriteDataE  = op_b;
   assign SrcBE       = q.ctrl[0] ? q.imm : op_b;
   assign ALUControlE = q.aluctl;
   assign CtrlE       = q.ctrl;
   assign PCE         = q.pc;
   assign ImmExtE     = q.imm;
   assign Rs1E        = q.rs1;
   assign Rs2E        = q.rs2;
   assign RdE         = q.rd;
   assign ValidE      = q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// Internal-forwarding checks build when ID_EX_INTERNAL_FWD_EN is set.
module tb_id_ex_stage;

   logic        clk;
   logic        reset_n;
   logic        StallE, FlushE, ValidD;
   logic [31:0] PCD, RD1D, RD2D, ImmExtD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic [2:0]  ALUControlD;
   logic [6:0]  CtrlD;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ALUResultM, ResultW;
   logic [4:0]  RdM, RdW;
   logic        RegWriteM, RegWriteW;
   logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
   logic [2:0]  ALUControlE;
   logic [6:0]  CtrlE;
   logic [4:0]  Rs1E, Rs2E, RdE;
   logic        ValidE;

   int total = 0;
   int bad = 0;

   id_ex_stage #(.word_width(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
      .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ALUControlD(ALUControlD), .CtrlD(CtrlD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUResultM(ALUResultM), .ResultW(ResultW),
      .RdM(RdM), .RegWriteM(RegWriteM),
      .RdW(RdW), .RegWriteW(RegWriteW),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
      .ALUControlE(ALUControlE), .CtrlE(CtrlE),
      .PCE(PCE), .ImmExtE(ImmExtE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ValidE(ValidE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      StallE = 0; FlushE = 0; ValidD = 0;
      PCD = 0; RD1D = 0; RD2D = 0; ImmExtD = 0;
      Rs1D = 0; Rs2D = 0; RdD = 0;
      ALUControlD = 0; CtrlD = 0;
      ForwardAE = 0; ForwardBE = 0;
      ALUResultM = 0; ResultW = 0;
      RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
      tick();
      chk("rst_valid", {31'd0, ValidE}, 32'd0);
      chk("rst_ctrl", {25'd0, CtrlE}, 32'd0);
      reset_n = 1'b1;

      // nonzero state, then reset mid-stall
      ValidD = 1; CtrlD = 7'h7E; ALUControlD = 3'b001;
      RD1D = 32'h55; RD2D = 32'h66; PCD = 32'h40;
      Rs1D = 5'd3; Rs2D = 5'd9; RdD = 5'd17;
      tick();
      chk("load_ctrl", {25'd0, CtrlE}, 32'h7E);
      chk("load_valid", {31'd0, ValidE}, 32'd1);
      chk("load_alu", {29'd0, ALUControlE}, 32'd1);
      chk("load_rs1", {27'd0, Rs1E}, 32'd3);
      chk("load_rs2", {27'd0, Rs2E}, 32'd9);
      chk("load_rd", {27'd0, RdE}, 32'd17);
      StallE = 1;
      tick();
      chk("stall_pc_pre", PCE, 32'h40);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_srca", SrcAE, 32'd0);
      chk("midrst_pc", PCE, 32'd0);
      chk("midrst_ctrl", {25'd0, CtrlE}, 32'd0);
      chk("midrst_valid", {31'd0, ValidE}, 32'd0);
      reset_n = 1'b1;
      StallE = 0;

      RD1D = 32'd5; RD2D = 32'd7; CtrlD = 7'h40;
      tick();
      chk("post_srca", SrcAE, 32'd5);
      chk("post_srcb", SrcBE, 32'd7);

      // immediate select
      ImmExtD = 32'hFFFFFFF0; CtrlD = 7'h41; RD2D = 32'd3;
      tick();
      chk("imm_srcb", SrcBE, 32'hFFFFFFF0);
      chk("imm_wd", WriteDataE, 32'd3);
      chk("imm_reg", ImmExtE, 32'hFFFFFFF0);

      // stall holds
      PCD = 32'h100;
      tick();
      chk("stall_load", PCE, 32'h100);
      StallE = 1; PCD = 32'h104;
      tick();
      chk("stall_1", PCE, 32'h100);
      tick();
      chk("stall_2", PCE, 32'h100);
      tick();
      chk("stall_3", PCE, 32'h100);
      StallE = 0;
      tick();
      chk("stall_rel", PCE, 32'h104);

      // flush wins over stall
      CtrlD = 7'h7F; ValidD = 1;
      tick();
      chk("pre_flush", {25'd0, CtrlE}, 32'h7F);
      StallE = 1; FlushE = 1;
      tick();
      chk("flush_ctrl", {25'd0, CtrlE}, 32'd0);
      chk("flush_valid", {31'd0, ValidE}, 32'd0);
      chk("flush_pc", PCE, 32'd0);
      StallE = 0; FlushE = 0;

      // invalid slot kills control, keeps data
      ValidD = 0; CtrlD = 7'h7F; RD1D = 32'd9;
      tick();
      chk("inv_ctrl", {25'd0, CtrlE}, 32'd0);
      chk("inv_valid", {31'd0, ValidE}, 32'd0);
      chk("inv_data", SrcAE, 32'd9);

      ValidD = 1; CtrlD = 7'h40;
      RD1D = 32'h11; RD2D = 32'h22;
      ALUResultM = 32'hAA; ResultW = 32'hBB;
`ifdef ID_EX_INTERNAL_FWD_EN
      Rs1D = 5'd0; Rs2D = 5'd6;
      ForwardAE = 2'b10; ForwardBE = 2'b10;
      tick();
      RdM = 5'd0; RegWriteM = 1; RegWriteW = 0;
      #1;
      chk("ifwd_x0", SrcAE, 32'h11);
      chk("ifwd_nomatch", SrcBE, 32'h22);
      Rs1D = 5'd4; Rs2D = 5'd4;
      tick();
      RdM = 5'd4; RdW = 5'd4; RegWriteM = 1; RegWriteW = 1;
      #1;
      chk("ifwd_mem_win", SrcAE, 32'hAA);
      RegWriteM = 0;
      #1;
      chk("ifwd_wb", SrcBE, 32'hBB);
      chk("ifwd_wb_wd", WriteDataE, 32'hBB);
`else
      tick();
      ForwardAE = 2'b10; ForwardBE = 2'b01;
      #1;
      chk("fwd_a_mem", SrcAE, 32'hAA);
      chk("fwd_b_wb", SrcBE, 32'hBB);
      chk("fwd_wd_wb", WriteDataE, 32'hBB);
      ForwardAE = 2'b11; ForwardBE = 2'b10;
      #1;
      chk("fwd_a_11", SrcAE, 32'h11);
      chk("fwd_b_mem", SrcBE, 32'hAA);
      ForwardBE = 2'b00;
      #1;
      chk("fwd_b_00", SrcBE, 32'h22);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
